// File: rtl/beam_trigger_gate_if.sv
// rtl/beam_trigger_gate_if.sv - trigger, mask, holdoff and scaler readout bundle for beam_trigger_gate
interface beam_trigger_gate_if #(
  parameter int NBEAMS    = 2,
  parameter int HOLDOFF_W = 8,
  parameter int SCALER_W  = 16,
  parameter int IDX_W     = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
);
  logic [NBEAMS-1:0]    trigger_i;
  logic [NBEAMS-1:0]    mask_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 trig_o;
  logic [NBEAMS-1:0]    trig_beams_o;
  logic [IDX_W-1:0]     scal_idx_i;
  logic [SCALER_W-1:0]  scal_o;
  logic                 scal_valid_o;

  modport master (
    output trigger_i, mask_i, holdoff_i, scal_idx_i,
    input  trig_o, trig_beams_o, scal_o, scal_valid_o
  );

  modport slave (
    input  trigger_i, mask_i, holdoff_i, scal_idx_i,
    output trig_o, trig_beams_o, scal_o, scal_valid_o
  );
endinterface

// File: rtl/beam_trigger_gate.sv
// rtl/beam_trigger_gate.sv - per-beam edge detect, merged trigger with holdoff, periodic rate scalers
module beam_trigger_gate #(
  parameter int NBEAMS      = 2,
  parameter int HOLDOFF_W   = 8,
  parameter int SCALER_W    = 16,
  parameter int SCAL_PERIOD = 1024
) (
  input logic               clk_i,
  input logic               rst_n_i,
  beam_trigger_gate_if.slave bus
);
  localparam int IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int PCNT_W = $clog2(SCAL_PERIOD);

  logic [NBEAMS-1:0]    q1, q2, edge_v, qual;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [PCNT_W-1:0]    per_cnt;
  logic                 tc;
  logic                 trig_q;
  logic [NBEAMS-1:0]    beams_q;
  logic                 valid_q;
  logic [SCALER_W-1:0]  scal_q, scal_sel;
  logic [SCALER_W-1:0]  live    [NBEAMS];
  logic [SCALER_W-1:0]  latched [NBEAMS];

  function automatic logic [SCALER_W-1:0] sat_inc(input logic [SCALER_W-1:0] v, input logic inc);
    return (inc && (v != {SCALER_W{1'b1}})) ? v + SCALER_W'(1) : v;
  endfunction

  assign edge_v = q1 & ~q2;
  assign qual   = edge_v & ~bus.mask_i;
  assign tc     = (per_cnt == PCNT_W'(SCAL_PERIOD - 1));

  // An index with no matching beam leaves the readout at zero.
  always_comb begin
    scal_sel = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (bus.scal_idx_i == IDX_W'(b)) scal_sel = latched[b];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q1       <= '0;
      q2       <= '0;
      hold_cnt <= '0;
      trig_q   <= 1'b0;
      beams_q  <= '0;
      per_cnt  <= '0;
      valid_q  <= 1'b0;
      scal_q   <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        live[b]    <= '0;
        latched[b] <= '0;
      end
    end else begin
      q1 <= bus.trigger_i;
      q2 <= q1;

      // Edges arriving while holdoff is running are dropped, not queued.
      if ((|qual) && (hold_cnt == '0)) begin
        trig_q   <= 1'b1;
        beams_q  <= qual;
        hold_cnt <= bus.holdoff_i;
      end else begin
        trig_q  <= 1'b0;
        beams_q <= '0;
        if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLDOFF_W'(1);
      end

      per_cnt <= tc ? '0 : per_cnt + PCNT_W'(1);
      valid_q <= tc;
      scal_q  <= scal_sel;

      // The terminal-count edge goes into the latched value so nothing straddles the boundary.
      for (int b = 0; b < NBEAMS; b++) begin
        if (tc) begin
          latched[b] <= sat_inc(live[b], edge_v[b]);
          live[b]    <= '0;
        end else begin
          live[b] <= sat_inc(live[b], edge_v[b]);
        end
      end
    end
  end

  assign bus.trig_o       = trig_q;
  assign bus.trig_beams_o = beams_q;
  assign bus.scal_o       = scal_q;
  assign bus.scal_valid_o = valid_q;
endmodule

// File: tb/tb_beam_trigger_gate.sv
// tb/tb_beam_trigger_gate.sv - randomized and directed bench for beam_trigger_gate against a timestamp model
module tb_beam_trigger_gate;
  localparam int NB  = 3;
  localparam int HW  = 8;
  localparam int SW  = 4;
  localparam int PER = 64;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  beam_trigger_gate_if #(.NBEAMS(NB), .HOLDOFF_W(HW), .SCALER_W(SW)) bus ();

  beam_trigger_gate #(
    .NBEAMS(NB), .HOLDOFF_W(HW), .SCALER_W(SW), .SCAL_PERIOD(PER)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Model: sample history by clock index, last fire timestamp, per-period edge totals.
  logic [NB-1:0] hist[$];
  int e;
  int last_fire;
  int last_h;
  int acc[NB];
  int lat[NB];
  int fires;

  task automatic model_reset();
    hist = '{3'b000, 3'b000};
    e = 0;
    last_fire = -100000;
    last_h = 0;
    for (int b = 0; b < NB; b++) begin
      acc[b] = 0;
      lat[b] = 0;
    end
  endtask

  task automatic cyc(input logic [NB-1:0] t, input logic [NB-1:0] m, input logic [HW-1:0] h,
                     input logic [1:0] ix);
    logic [NB-1:0] ev, q, exp_beams;
    logic exp_trig, exp_valid;
    logic [SW-1:0] exp_scal;
    bus.trigger_i  = t;
    bus.mask_i     = m;
    bus.holdoff_i  = h;
    bus.scal_idx_i = ix;
    @(posedge clk);
    #1;
    e++;
    hist.push_back(t);
    ev = hist[hist.size()-2] & ~hist[hist.size()-3];
    q = ev & ~m;
    exp_trig = (q != '0) && (e > last_fire + last_h);
    exp_beams = exp_trig ? q : '0;
    if (exp_trig) begin
      last_fire = e;
      last_h = int'(h);
      fires++;
    end
    exp_scal = (int'(ix) < NB) ? SW'(lat[ix]) : '0;
    for (int b = 0; b < NB; b++) acc[b] += int'(ev[b]);
    exp_valid = (e % PER) == 0;
    if (exp_valid) begin
      for (int b = 0; b < NB; b++) begin
        lat[b] = (acc[b] > SMAX) ? SMAX : acc[b];
        acc[b] = 0;
      end
    end
    checks++;
    assert (bus.trig_o === exp_trig) else begin
      errors++;
      $error("FAIL trig_o e=%0d got=%b exp=%b", e, bus.trig_o, exp_trig);
    end
    checks++;
    assert (bus.trig_beams_o === exp_beams) else begin
      errors++;
      $error("FAIL trig_beams_o e=%0d got=%b exp=%b", e, bus.trig_beams_o, exp_beams);
    end
    checks++;
    assert (bus.scal_o === exp_scal) else begin
      errors++;
      $error("FAIL scal_o e=%0d idx=%0d got=%0d exp=%0d", e, ix, bus.scal_o, exp_scal);
    end
    checks++;
    assert (bus.scal_valid_o === exp_valid) else begin
      errors++;
      $error("FAIL scal_valid_o e=%0d got=%b exp=%b", e, bus.scal_valid_o, exp_valid);
    end
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any further clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({bus.trig_o, bus.trig_beams_o, bus.scal_o, bus.scal_valid_o} === '0) else begin
      errors++;
      $error("FAIL reset_outputs got=%b exp=0", {bus.trig_o, bus.trig_beams_o, bus.scal_o, bus.scal_valid_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NB-1:0] t;
    int f0;
    bus.trigger_i = '0;
    bus.mask_i = '0;
    bus.holdoff_i = '0;
    bus.scal_idx_i = '0;
    fires = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Level held high: one pulse only.
    f0 = fires;
    for (int i = 0; i < 20; i++) cyc(3'b001, 3'b000, 8'd0, 2'd0);
    checks++;
    assert (fires - f0 == 1) else begin
      errors++;
      $error("FAIL single_pulse got=%0d exp=1", fires - f0);
    end
    cyc(3'b000, 3'b000, 8'd0, 2'd0);

    // Holdoff 5 with beam0 pulsing every third cycle.
    for (int i = 0; i < 30; i++) cyc((i % 3 == 0) ? 3'b001 : 3'b000, 3'b000, 8'd5, 2'd0);

    // Masked beam0 with simultaneous beam1 edge, then beam0 alone.
    cyc(3'b000, 3'b001, 8'd0, 2'd0);
    cyc(3'b011, 3'b001, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b001, 8'd0, 2'd0);
    cyc(3'b001, 3'b001, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b001, 8'd0, 2'd0);

    // Seven beam1 edges with the last landing on the terminal count, then an empty period.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(3'b010, 3'b000, 8'd0, 2'd1);
      cyc(3'b000, 3'b000, 8'd0, 2'd1);
    end
    while (((e + 1) % PER) != PER - 1) cyc(3'b000, 3'b000, 8'd0, 2'd1);
    cyc(3'b010, 3'b000, 8'd0, 2'd1);
    for (int i = 0; i < PER + 4; i++) cyc(3'b000, 3'b000, 8'd0, 2'd1);

    // Saturation: twenty beam0 edges in one period; out-of-range index reads zero.
    for (int i = 0; i < 20; i++) begin
      cyc(3'b001, 3'b000, 8'd0, 2'd3);
      cyc(3'b000, 3'b000, 8'd0, 2'd0);
    end
    for (int i = 0; i < PER; i++) cyc(3'b000, 3'b000, 8'd0, (i % 2 == 0) ? 2'd0 : 2'd3);

    // Reset during a long holdoff with a partial period in flight.
    cyc(3'b100, 3'b000, 8'd200, 2'd2);
    for (int i = 0; i < 4; i++) cyc(3'b000, 3'b000, 8'd200, 2'd2);
    cyc(3'b010, 3'b000, 8'd200, 2'd2);
    cyc(3'b000, 3'b000, 8'd200, 2'd2);
    do_reset();
    f0 = fires;
    for (int i = 0; i < 4; i++) cyc((i == 0) ? 3'b100 : 3'b000, 3'b000, 8'd0, 2'd2);
    checks++;
    assert (fires - f0 == 1) else begin
      errors++;
      $error("FAIL post_reset_fire got=%0d exp=1", fires - f0);
    end
    for (int i = 0; i < PER + 4; i++) cyc(3'b000, 3'b000, 8'd0, 2'd2);

    // Randomized traffic with occasional resets.
    t = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) t = NB'($urandom);
      cyc(t, ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0, HW'($urandom_range(0, 6)),
          2'($urandom_range(0, 3)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
